// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN front-end blocks.
package cnn_pkg;

  localparam int DEFAULT_IMG_WIDTH  = 28;
  localparam int DEFAULT_IMG_HEIGHT = 28;
  localparam int DEFAULT_KDIM       = 3;
  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef logic [DEFAULT_DATA_WIDTH-1:0] pixel_t;

  typedef enum logic {
    FILL   = 1'b0,
    STREAM = 1'b1
  } state_t;

endpackage

// File: rtl/line_buffer.sv
// One image row of pixel storage; combinational read of the old value,
// write of the new value at the same address on the clock edge.
module line_buffer
  import cnn_pkg::*;
#(
  parameter int DEPTH      = DEFAULT_IMG_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  assign dout = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
  end

endmodule

// File: rtl/window_gen.sv
// Sliding KDIMxKDIM window generator over a raster pixel stream ("valid"
// windows only), feeding the convolver with a one-cycle strobe per window.
module window_gen
  import cnn_pkg::*;
#(
  parameter int IMG_WIDTH  = DEFAULT_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEFAULT_IMG_HEIGHT,
  parameter int KDIM       = DEFAULT_KDIM,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pix_valid,
  input  logic                  pix_sof,
  input  logic [DATA_WIDTH-1:0] pix_data,
  output logic [DATA_WIDTH-1:0] window [0:KDIM*KDIM-1],
  output logic                  window_valid,
  output logic                  frame_done
);

  localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int KS = KDIM * KDIM;

  logic [CW-1:0] col, eff_col, col_nxt;
  logic [RW-1:0] row, eff_row, row_nxt;
  state_t        state, eff_state, state_nxt;
  logic          at_row_end, at_frame_end, emit;

  logic [DATA_WIDTH-1:0] lb_din  [0:KDIM-2];
  logic [DATA_WIDTH-1:0] lb_out  [0:KDIM-2];
  logic [DATA_WIDTH-1:0] col_vec [0:KDIM-1];

  // A start-of-frame pixel overrides the counters and state as if at (0,0).
  always_comb begin
    eff_col      = pix_sof ? '0 : col;
    eff_row      = pix_sof ? '0 : row;
    eff_state    = pix_sof ? FILL : state;
    at_row_end   = (eff_col == CW'(IMG_WIDTH - 1));
    at_frame_end = at_row_end && (eff_row == RW'(IMG_HEIGHT - 1));
    col_nxt      = at_row_end ? '0 : eff_col + CW'(1);
    row_nxt      = eff_row;
    if (at_row_end) row_nxt = at_frame_end ? '0 : eff_row + RW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col   <= '0;
      row   <= '0;
      state <= FILL;
    end else if (pix_valid) begin
      col   <= col_nxt;
      row   <= row_nxt;
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (pix_valid) begin
      case (eff_state)
        FILL:    state_nxt = (at_row_end && eff_row == RW'(KDIM - 2)) ? STREAM : FILL;
        STREAM:  state_nxt = at_frame_end ? FILL : STREAM;
        default: state_nxt = FILL;
      endcase
    end
  end

  always_comb begin
    emit = pix_valid && (eff_state == STREAM) && (eff_col >= CW'(KDIM - 1));
  end

  // Line buffer chain: lb[0] holds the newest buffered row.
  assign lb_din[0] = pix_data;
  for (genvar i = 1; i < KDIM - 1; i++) begin : g_chain
    assign lb_din[i] = lb_out[i-1];
  end

  for (genvar i = 0; i < KDIM - 1; i++) begin : g_lb
    line_buffer #(
      .DEPTH      (IMG_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_lb (
      .clk  (clk),
      .we   (pix_valid),
      .addr (eff_col),
      .din  (lb_din[i]),
      .dout (lb_out[i])
    );
  end

  for (genvar r = 0; r < KDIM - 1; r++) begin : g_colvec
    assign col_vec[r] = lb_out[KDIM-2-r];
  end
  assign col_vec[KDIM-1] = pix_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < KS; i++) window[i] <= '0;
    end else if (pix_valid) begin
      for (int r = 0; r < KDIM; r++) begin
        for (int c = 0; c < KDIM - 1; c++) window[r*KDIM+c] <= window[r*KDIM+c+1];
        window[r*KDIM+KDIM-1] <= col_vec[r];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      window_valid <= emit;
      frame_done   <= emit && at_frame_end;
    end
  end

endmodule

// File: tb/tb_window_gen.sv
// Directed and randomized bench for window_gen against an image-array reference.
module tb_window_gen;

  localparam int W = 5;
  localparam int H = 5;
  localparam int K = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pv = 1'b0, ps = 1'b0;
  logic [7:0] pd = '0;
  logic [7:0] win5 [0:8];
  logic       wv5, fd5;

  logic       pv3 = 1'b0, ps3 = 1'b0;
  logic [7:0] pd3 = '0;
  logic [7:0] win3 [0:8];
  logic       wv3, fd3;

  always #5 clk = ~clk;

  window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .KDIM(K), .DATA_WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .pix_valid(pv), .pix_sof(ps), .pix_data(pd),
    .window(win5), .window_valid(wv5), .frame_done(fd5)
  );

  window_gen #(.IMG_WIDTH(3), .IMG_HEIGHT(3), .KDIM(3), .DATA_WIDTH(8)) u_dut3 (
    .clk(clk), .rst(rst), .pix_valid(pv3), .pix_sof(ps3), .pix_data(pd3),
    .window(win3), .window_valid(wv3), .frame_done(fd3)
  );

  int checks = 0;
  int passed = 0;

  // Reference model: the image as a 2-D array plus the current raster position.
  logic [7:0]  img [0:H-1][0:W-1];
  int          mr = 0, mc = 0;
  logic        exp_v, exp_fd;
  logic [71:0] exp_win;

  logic [71:0] cur_seq[$];
  logic [71:0] ref_seq[$];
  int          nwin, nfd;
  int          first_px;
  logic [71:0] first_win, last_win;

  int lit_first[9] = '{1, 2, 3, 6, 7, 8, 11, 12, 13};
  int lit_last[9]  = '{13, 14, 15, 18, 19, 20, 23, 24, 25};
  int lit_f2[9]    = '{101, 102, 103, 106, 107, 108, 111, 112, 113};
  int lit_3x3[9]   = '{1, 2, 3, 4, 5, 6, 7, 8, 9};

  function automatic logic [71:0] pack(input logic [7:0] w [0:8]);
    logic [71:0] v = '0;
    for (int i = 0; i < 9; i++) v = (v << 8) | 72'(w[i]);
    return v;
  endfunction

  function automatic logic [71:0] pack_int(input int a[9]);
    logic [71:0] v = '0;
    for (int i = 0; i < 9; i++) v = (v << 8) | 72'(a[i] & 8'hff);
    return v;
  endfunction

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model(input bit v, input bit sof, input logic [7:0] d);
    exp_v  = 1'b0;
    exp_fd = 1'b0;
    if (v) begin
      if (sof) begin mr = 0; mc = 0; end
      img[mr][mc] = d;
      if (mr >= K - 1 && mc >= K - 1) begin
        exp_v   = 1'b1;
        exp_fd  = (mr == H - 1) && (mc == W - 1);
        exp_win = '0;
        for (int r = 0; r < K; r++)
          for (int c = 0; c < K; c++)
            exp_win = (exp_win << 8) | 72'(img[mr-K+1+r][mc-K+1+c]);
      end
      mc++;
      if (mc == W) begin
        mc = 0;
        mr++;
        if (mr == H) mr = 0;
      end
    end
  endtask

  task automatic step(input bit v, input bit sof, input logic [7:0] d);
    pv = v; ps = sof & v; pd = d;
    @(posedge clk);
    model(v, sof & v, d);
    #1;
    check("window_valid", 72'(wv5), 72'(exp_v));
    check("frame_done", 72'(fd5), 72'(exp_fd));
    if (exp_v) check("window", pack(win5), exp_win);
    if (wv5) begin
      nwin++;
      cur_seq.push_back(pack(win5));
      if (nwin == 1) begin first_px = int'(d); first_win = pack(win5); end
    end
    if (fd5) begin nfd++; last_win = pack(win5); end
    pv = 1'b0; ps = 1'b0;
  endtask

  task automatic clr();
    nwin = 0; nfd = 0; first_px = -1;
    first_win = 'x; last_win = 'x;
    cur_seq.delete();
  endtask

  task automatic frame(input int base, input bit sof, input int gap);
    for (int i = 0; i < W * H; i++) begin
      step(1'b1, sof && (i == 0), 8'(base + i));
      repeat (gap) step(1'b0, 1'b0, 8'h00);
    end
    step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic cmp_seq(input string tag);
    check({tag, "_len"}, 72'(cur_seq.size()), 72'(ref_seq.size()));
    for (int i = 0; i < cur_seq.size() && i < ref_seq.size(); i++)
      check(tag, cur_seq[i], ref_seq[i]);
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_valid", 72'(wv5), 72'd0);
    check("rst_done", 72'(fd5), 72'd0);
    check("rst_window", pack(win5), 72'd0);
    @(negedge clk);
    rst = 1'b1;

    // Scenario 1: clean frame, back-to-back
    clr();
    frame(1, 1'b1, 0);
    check("s1_count", 72'(nwin), 72'd9);
    check("s1_done_count", 72'(nfd), 72'd1);
    check("s1_first_win", first_win, pack_int(lit_first));
    check("s1_first_after_px", 72'(first_px), 72'd13);
    check("s1_last_win", last_win, pack_int(lit_last));
    ref_seq = cur_seq;

    // Scenario 2: two idle cycles after every pixel
    clr();
    frame(1, 1'b1, 2);
    cmp_seq("s2_seq");

    // Scenario 3: two consecutive frames
    clr();
    for (int i = 0; i < W * H; i++) step(1'b1, i == 0, 8'(1 + i));
    for (int i = 0; i < W * H; i++) step(1'b1, 1'b0, 8'(101 + i));
    step(1'b0, 1'b0, 8'h00);
    check("s3_count", 72'(nwin), 72'd18);
    check("s3_done_count", 72'(nfd), 72'd2);
    check("s3_f2_first", (cur_seq.size() > 9) ? cur_seq[9] : 72'bx, pack_int(lit_f2));

    // Scenario 4: aborted frame resynchronised by pix_sof
    clr();
    for (int i = 0; i < 7; i++) step(1'b1, i == 0, 8'(200 + i));
    frame(1, 1'b1, 0);
    check("s4_done_count", 72'(nfd), 72'd1);
    cmp_seq("s4_seq");

    // Scenario 5: asynchronous reset mid-frame
    clr();
    for (int i = 0; i < 17; i++) step(1'b1, i == 0, 8'(1 + i));
    #2 rst = 1'b0;
    mr = 0; mc = 0;
    #1;
    check("s5_rst_valid", 72'(wv5), 72'd0);
    check("s5_rst_done", 72'(fd5), 72'd0);
    check("s5_rst_window", pack(win5), 72'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    clr();
    frame(1, 1'b0, 0);
    cmp_seq("s5_seq");

    // Scenario 6: 3x3 image, single window
    for (int i = 0; i < 9; i++) begin
      pv3 = 1'b1; ps3 = (i == 0); pd3 = 8'(i + 1);
      @(posedge clk);
      #1;
      check("s6_valid", 72'(wv3), 72'(i == 8));
      check("s6_done", 72'(fd3), 72'(i == 8));
      if (i == 8) check("s6_window", pack(win3), pack_int(lit_3x3));
    end
    pv3 = 1'b0; ps3 = 1'b0;
    @(posedge clk);
    #1;
    check("s6_valid_after", 72'(wv3), 72'd0);

    // Scenario 7: random data, random gaps, occasional resync
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < W * H; i++) begin
        repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, 8'h00);
        step(1'b1, (i == 0) || ($urandom_range(0, 30) == 0), 8'($urandom));
      end
    end
    step(1'b0, 1'b0, 8'h00);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
